// File: rtl/bank_controller_pkg.sv
// Shared types for the byte-banked memory controller: transfer sizes,
// FSM states and the fixed bank count.
package bank_controller_pkg;

    localparam int BANKS_COUNT = 4;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RESPOND = 2'b10
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/bank_controller_byte_lane_router.sv
// Combinational lane steering: byte k of an access lives in bank (offset+k) mod 4,
// and banks below the offset sit one row further on.
module bank_controller_byte_lane_router
    import bank_controller_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic [1:0]                    offset,
    input  logic [1:0]                    size,
    input  logic [ADDR_W-1:0]             row,
    input  logic                          sign_ext,
    input  logic [31:0]                   wdata,
    input  logic [BANKS_COUNT*8-1:0]      rdata,
    output logic [BANKS_COUNT-1:0]        enable,
    output logic [BANKS_COUNT*ADDR_W-1:0] address,
    output logic [BANKS_COUNT*8-1:0]      bank_wdata,
    output logic [31:0]                   load_data
);

    logic [2:0]  nbytes;
    logic [1:0]  lane;
    logic [1:0]  sel;
    logic [31:0] raw;

    always_comb begin
        enable     = '0;
        address    = '0;
        bank_wdata = '0;
        load_data  = '0;
        raw        = '0;
        lane       = '0;
        sel        = '0;
        nbytes     = size_bytes(size);

        for (int b = 0; b < BANKS_COUNT; b++) begin
            lane = 2'(b) - offset;
            if ({1'b0, lane} < nbytes) begin
                enable[b] = 1'b1;
                // row + 1 wraps to row 0 naturally at the top of the bank
                address[b*ADDR_W +: ADDR_W] = (2'(b) < offset) ? row + 1'b1 : row;
                bank_wdata[b*8 +: 8] = wdata[{lane, 3'b000} +: 8];
            end
        end

        for (int k = 0; k < BANKS_COUNT; k++) begin
            sel = offset + 2'(k);
            raw[k*8 +: 8] = rdata[{sel, 3'b000} +: 8];
        end

        case (size)
            BYTE:    load_data = {{24{sign_ext & raw[7]}}, raw[7:0]};
            HALF:    load_data = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default: load_data = raw;
        endcase
    end

endmodule

// File: rtl/bank_controller.sv
// Single-request controller over four byte-wide banks: accept in IDLE, one bank
// cycle in ACCESS, one-cycle response in RESPOND.
module bank_controller
    import bank_controller_pkg::*;
#(
    parameter int  MEMORY_SIZE = 4096,
    parameter int  BANKS_COUNT = 4,
    localparam int ADDR_W      = $clog2(MEMORY_SIZE)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_W+1:0]             req_address_i,
    input  logic                          req_write_i,
    input  logic [1:0]                    req_size_i,
    input  logic                          req_signed_i,
    input  logic [31:0]                   req_data_i,
    output logic                          rsp_valid_o,
    output logic [31:0]                   rsp_data_o,
    output logic                          rsp_error_o,
    output logic [BANKS_COUNT-1:0]        bank_enable_o,
    output logic [BANKS_COUNT-1:0]        bank_write_o,
    output logic [BANKS_COUNT*ADDR_W-1:0] bank_address_o,
    output logic [BANKS_COUNT*8-1:0]      bank_wdata_o,
    input  logic [BANKS_COUNT*8-1:0]      bank_rdata_i,
    output logic [1:0]                    dbg_state_o
);

    state_e              state, state_next;
    logic [ADDR_W-1:0]   row_q;
    logic [1:0]          offset_q;
    logic                write_q;
    size_e               size_q;
    logic                signed_q;
    logic [31:0]         data_q;

    logic [BANKS_COUNT-1:0]        route_en;
    logic [BANKS_COUNT*ADDR_W-1:0] route_addr;
    logic [BANKS_COUNT*8-1:0]      route_wdata;
    logic [31:0]                   load_data;

    // Handshake: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both high; ready is high only in IDLE, so inputs are
    // ignored in every other state. Responses have no backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            row_q    <= '0;
            offset_q <= '0;
            write_q  <= 1'b0;
            size_q   <= BYTE;
            signed_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid_i) begin
                row_q    <= req_address_i[ADDR_W+1:2];
                offset_q <= req_address_i[1:0];
                write_q  <= req_write_i;
                size_q   <= size_e'(req_size_i);
                signed_q <= req_signed_i;
                data_q   <= req_data_i;
            end
        end
    end

    bank_controller_byte_lane_router #(.ADDR_W(ADDR_W)) u_router (
        .offset     (offset_q),
        .size       (size_q),
        .row        (row_q),
        .sign_ext   (signed_q),
        .wdata      (data_q),
        .rdata      (bank_rdata_i),
        .enable     (route_en),
        .address    (route_addr),
        .bank_wdata (route_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_next     = state;
        req_ready_o    = 1'b0;
        bank_enable_o  = '0;
        bank_write_o   = '0;
        bank_address_o = '0;
        bank_wdata_o   = '0;
        rsp_valid_o    = 1'b0;
        rsp_error_o    = 1'b0;
        rsp_data_o     = '0;

        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    state_next = (req_size_i == ILLEGAL) ? RESPOND : ACCESS;
            end
            ACCESS: begin
                bank_enable_o  = route_en;
                bank_write_o   = route_en & {BANKS_COUNT{write_q}};
                bank_address_o = route_addr;
                bank_wdata_o   = route_wdata;
                state_next     = RESPOND;
            end
            RESPOND: begin
                rsp_valid_o = 1'b1;
                rsp_error_o = (size_q == ILLEGAL);
                // read bytes arrive from the banks during this cycle
                if (!write_q && size_q != ILLEGAL)
                    rsp_data_o = load_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state_o = state;

endmodule

// File: tb/tb_bank_controller.sv
// Bench for bank_controller: behavioural bank memories, a flat byte-array reference
// model feeding an expected-response queue, and per-scenario tasks.
module tb_bank_controller;

  localparam int MEMORY_SIZE = 4096;
  localparam int ADDR_W      = 12;
  localparam int SPAN        = 4 * MEMORY_SIZE;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [ADDR_W+1:0]    req_address_i;
  logic                 req_write_i;
  logic [1:0]           req_size_i;
  logic                 req_signed_i;
  logic [31:0]          req_data_i;
  logic                 rsp_valid_o;
  logic [31:0]          rsp_data_o;
  logic                 rsp_error_o;
  logic [3:0]           bank_enable_o;
  logic [3:0]           bank_write_o;
  logic [4*ADDR_W-1:0]  bank_address_o;
  logic [31:0]          bank_wdata_o;
  logic [31:0]          bank_rdata_i = '0;
  logic [1:0]           dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  logic [7:0] mem [4][MEMORY_SIZE] = '{default: '{default: 8'h00}};
  logic [7:0] ref_mem [SPAN] = '{default: 8'h00};

  logic [3:0]          seen_en;
  logic [4*ADDR_W-1:0] seen_addr;
  logic [31:0]         seen_wd;
  int                  lat;

  bank_controller #(.MEMORY_SIZE(MEMORY_SIZE), .BANKS_COUNT(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_address_i  (req_address_i),
    .req_write_i    (req_write_i),
    .req_size_i     (req_size_i),
    .req_signed_i   (req_signed_i),
    .req_data_i     (req_data_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_error_o    (rsp_error_o),
    .bank_enable_o  (bank_enable_o),
    .bank_write_o   (bank_write_o),
    .bank_address_o (bank_address_o),
    .bank_wdata_o   (bank_wdata_o),
    .bank_rdata_i   (bank_rdata_i),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // synchronous byte-wide banks, read data one cycle after enable
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_enable_o[b]) begin
        if (bank_write_o[b])
          mem[b][bank_address_o[b*ADDR_W +: ADDR_W]] <= bank_wdata_o[b*8 +: 8];
        bank_rdata_i[b*8 +: 8] <= mem[b][bank_address_o[b*ADDR_W +: ADDR_W]];
      end
    end
  end

  // scoreboard: compare each response against the oldest expectation
  always @(negedge clk) begin
    logic [32:0] exp;
    if (rsp_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got err=%0b data=%08h required no response", rsp_error_o, rsp_data_o);
      end else begin
        exp = exp_q.pop_front();
        if ({rsp_error_o, rsp_data_o} !== exp) begin
          errors++;
          $display("FAIL rsp_data got err=%0b data=%08h required err=%0b data=%08h",
                   rsp_error_o, rsp_data_o, exp[32], exp[31:0]);
        end
      end
    end
  end

  // reference model: flat little-endian byte space
  task automatic model(input logic [ADDR_W+1:0] a, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] d);
    logic [31:0] v;
    int n;
    if (sz == 2'b11) begin
      exp_q.push_back({1'b1, 32'h0});
      return;
    end
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (w) begin
      for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % SPAN] = d[8*k +: 8];
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(int'(a) + k) % SPAN];
      if (sg) for (int i = 8*n; i < 32; i++) v[i] = v[8*n-1];
      exp_q.push_back({1'b0, v});
    end
  endtask

  // driver: call at posedge+1 in IDLE; returns cycles from handshake to response (99 = none)
  task automatic send(input logic [ADDR_W+1:0] a, input logic w, input logic [1:0] sz,
                      input logic sg, input logic [31:0] d, output int l);
    model(a, w, sz, sg, d);
    req_valid_i = 1'b1;
    req_address_i = a;
    req_write_i = w;
    req_size_i = sz;
    req_signed_i = sg;
    req_data_i = d;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    l = 99;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        seen_en = bank_enable_o;
        seen_addr = bank_address_o;
        seen_wd = bank_wdata_o;
      end
      if (rsp_valid_o === 1'b1) begin
        l = c;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_address_i = '0;
    req_write_i = 1'b0;
    req_size_i = 2'b00;
    req_signed_i = 1'b0;
    req_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || dbg_state_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got ready=%0b state=%0d required ready=1 state=0", req_ready_o, dbg_state_o);
    end
    checks++;
    if ({rsp_valid_o, rsp_error_o, rsp_data_o} !== 34'h0) begin
      errors++;
      $display("FAIL reset_rsp got valid=%0b err=%0b data=%08h required all zero", rsp_valid_o, rsp_error_o, rsp_data_o);
    end
    checks++;
    if ({bank_enable_o, bank_write_o, bank_address_o, bank_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_bank got en=%b wr=%b addr=%h wd=%h required all zero",
               bank_enable_o, bank_write_o, bank_address_o, bank_wdata_o);
    end
    @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_word_aligned();
    send(14'h004, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL word_store_latency got %0d required 2", lat); end
    checks++;
    if (seen_en !== 4'hF || seen_addr !== {12'd1, 12'd1, 12'd1, 12'd1}) begin
      errors++;
      $display("FAIL word_store_banks got en=%b addr=%h required en=1111 all rows 1", seen_en, seen_addr);
    end
    checks++;
    if (seen_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_wdata got %08h required deadbeef", seen_wd); end
    send(14'h004, 1'b0, 2'b10, 1'b0, 32'h0, lat);
    checks++;
    if (lat !== 2 || seen_en !== 4'hF) begin
      errors++;
      $display("FAIL word_load got lat=%0d en=%b required lat=2 en=1111", lat, seen_en);
    end
  endtask

  task automatic test_misaligned();
    send(14'h007, 1'b1, 2'b10, 1'b0, 32'h11223344, lat);
    checks++;
    if (seen_en !== 4'hF || seen_addr !== {12'd1, 12'd2, 12'd2, 12'd2}) begin
      errors++;
      $display("FAIL misaligned_rows got en=%b addr=%h required en=1111 b3=1 b2/b1/b0=2", seen_en, seen_addr);
    end
    checks++;
    if (mem[3][1] !== 8'h44 || mem[0][2] !== 8'h33 || mem[1][2] !== 8'h22 || mem[2][2] !== 8'h11) begin
      errors++;
      $display("FAIL misaligned_bytes got %02h %02h %02h %02h required 44 33 22 11",
               mem[3][1], mem[0][2], mem[1][2], mem[2][2]);
    end
    send(14'h007, 1'b0, 2'b10, 1'b0, 32'h0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL misaligned_load_latency got %0d required 2", lat); end
  endtask

  task automatic test_byte_sign();
    send(14'h002, 1'b1, 2'b00, 1'b0, 32'h00000080, lat);
    checks++;
    if (seen_en !== 4'b0100 || seen_wd[23:16] !== 8'h80 || seen_addr[2*ADDR_W +: ADDR_W] !== 12'd0) begin
      errors++;
      $display("FAIL byte_store got en=%b wd=%h addr=%h required en=0100 bank2 byte 80 row 0", seen_en, seen_wd, seen_addr);
    end
    send(14'h002, 1'b0, 2'b00, 1'b1, 32'h0, lat);
    checks++;
    if (seen_en !== 4'b0100) begin errors++; $display("FAIL byte_load_signed_en got %b required 0100", seen_en); end
    send(14'h002, 1'b0, 2'b00, 1'b0, 32'h0, lat);
    checks++;
    if (seen_en !== 4'b0100) begin errors++; $display("FAIL byte_load_unsigned_en got %b required 0100", seen_en); end
  endtask

  task automatic test_wrap();
    send(14'h3FFF, 1'b1, 2'b01, 1'b0, 32'h0000A55A, lat);
    checks++;
    if (seen_en !== 4'b1001 || seen_addr[3*ADDR_W +: ADDR_W] !== 12'd4095 || seen_addr[0 +: ADDR_W] !== 12'd0) begin
      errors++;
      $display("FAIL wrap_rows got en=%b addr=%h required en=1001 b3=4095 b0=0", seen_en, seen_addr);
    end
    checks++;
    if (mem[3][4095] !== 8'h5A || mem[0][0] !== 8'hA5) begin
      errors++;
      $display("FAIL wrap_bytes got %02h %02h required 5a a5", mem[3][4095], mem[0][0]);
    end
    send(14'h3FFF, 1'b0, 2'b01, 1'b0, 32'h0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL wrap_load_latency got %0d required 2", lat); end
  endtask

  task automatic test_illegal_back_to_back();
    model(14'h010, 1'b0, 2'b11, 1'b0, 32'h0);
    model(14'h004, 1'b0, 2'b10, 1'b0, 32'h0);
    req_valid_i = 1'b1;
    req_address_i = 14'h010;
    req_write_i = 1'b0;
    req_size_i = 2'b11;
    req_signed_i = 1'b0;
    @(posedge clk);
    #1 req_address_i = 14'h004;
    req_size_i = 2'b10;
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_error_o !== 1'b1 || req_ready_o !== 1'b0 || bank_enable_o !== 4'h0) begin
      errors++;
      $display("FAIL illegal_n1 got valid=%0b err=%0b ready=%0b en=%b required 1 1 0 0000",
               rsp_valid_o, rsp_error_o, req_ready_o, bank_enable_o);
    end
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || bank_enable_o !== 4'h0) begin
      errors++;
      $display("FAIL illegal_n2 got ready=%0b valid=%0b en=%b required 1 0 0000", req_ready_o, rsp_valid_o, bank_enable_o);
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bank_enable_o !== 4'hF) begin errors++; $display("FAIL followup_access got en=%b required 1111", bank_enable_o); end
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL followup_response got valid=%0b required 1", rsp_valid_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_access();
    req_valid_i = 1'b1;
    req_address_i = 14'h004;
    req_write_i = 1'b0;
    req_size_i = 2'b10;
    req_signed_i = 1'b0;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    checks++;
    if (bank_enable_o !== 4'hF) begin errors++; $display("FAIL abort_setup got en=%b required 1111", bank_enable_o); end
    rst_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 ||
        {bank_enable_o, bank_write_o, bank_address_o, bank_wdata_o} !== '0) begin
      errors++;
      $display("FAIL abort_immediate got ready=%0b valid=%0b en=%b addr=%h required 1 0 0 0",
               req_ready_o, rsp_valid_o, bank_enable_o, bank_address_o);
    end
    @(posedge clk);
    #1 rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b0 || bank_enable_o !== 4'h0) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d got valid=%0b en=%b required 0 0000", c, rsp_valid_o, bank_enable_o);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [ADDR_W+1:0] a;
    logic [1:0] sz;
    logic w, sg;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 14'($urandom_range(0, 31)) : 14'(SPAN - 1 - $urandom_range(0, 7));
      sz = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      send(a, w, sz, sg, $urandom, lat);
      checks++;
      if (lat !== ((sz == 2'b11) ? 1 : 2)) begin
        errors++;
        $display("FAIL random_latency addr=%h size=%0d got %0d required %0d", a, sz, lat, (sz == 2'b11) ? 1 : 2);
      end
      if (sz == 2'b11) begin
        checks++;
        if (seen_en !== 4'h0) begin errors++; $display("FAIL random_illegal_en got %b required 0000", seen_en); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_aligned();
    test_misaligned();
    test_byte_sign();
    test_wrap();
    test_illegal_back_to_back();
    test_reset_mid_access();
    test_random();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_controller.md
BANK_CONTROLLER -- requirements
Module: bank_controller

Interface
REQ-001 Parameter: MEMORY_SIZE, default 4096, bytes per bank; ADDR_W = clog2(MEMORY_SIZE).
REQ-002 Parameter: BANKS_COUNT, default 4, number of byte-wide banks; only the value 4 is supported.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_valid_i  in  1  request present.
REQ-007 req_ready_o  out  1  controller can accept a request.
REQ-008 req_address_i  in  ADDR_W+2  byte address.
REQ-009 req_write_i  in  1  1 = store, 0 = load.
REQ-010 req_size_i  in  2  transfer size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 req_signed_i  in  1  sign-extend load data.
REQ-012 req_data_i  in  32  store data, little-endian.
REQ-013 rsp_valid_o  out  1  one-cycle response pulse.
REQ-014 rsp_data_o  out  32  load result; 0 for stores and errors.
REQ-015 rsp_error_o  out  1  illegal size; qualified by rsp_valid_o.
REQ-016 bank_enable_o  out  4  per-bank port enable.
REQ-017 bank_write_o  out  4  per-bank write strobe.
REQ-018 bank_address_o  out  4 x ADDR_W  per-bank row address.
REQ-019 bank_wdata_o  out  4 x 8  per-bank write byte.
REQ-020 bank_rdata_i  in  4 x 8  per-bank read byte; valid the cycle after enable.

Function
REQ-021 Address mapping: offset = address[1:0]; row = address[ADDR_W+1:2]; byte k of an access targets byte address A+k, i.e. bank (offset+k) mod 4, row (A+k)>>2.
REQ-022 Misaligned half/word accesses complete in a single bank cycle; banks below offset use row+1.
REQ-023 Row+1 at the top row wraps to row 0.
REQ-024 FSM states: IDLE, ACCESS, RESPOND.
REQ-025 req_ready_o = 1 only in IDLE.
REQ-026 A handshake (valid & ready) in cycle N captures address, write, size, signed and data.
REQ-027 After the handshake, the FSM enters ACCESS in N+1, or RESPOND directly if size = 11.
REQ-028 Bank ports are driven only in ACCESS; all bank_* outputs are 0 in every other state.
REQ-029 In ACCESS, only the banks touched by the access have enable = 1; bank_write = enable & write.
REQ-030 In ACCESS, bank_wdata of the bank receiving byte k = req_data[8k+7:8k].
REQ-031 RESPOND lasts exactly one cycle: rsp_valid_o = 1, then return to IDLE.
REQ-032 Normal latency: handshake at N, rsp_valid_o at N+2, next accept at N+3 at the earliest.
REQ-033 Illegal-size latency: handshake at N, rsp_valid_o at N+1 with error = 1; no bank enable at any point.
REQ-034 Load assembly: byte k of rsp_data_o = bank_rdata_i of the bank for byte k.
REQ-035 Bits above the access size: zero-filled, or copies of the top accessed bit when req_signed_i = 1.
REQ-036 Stores: rsp_data_o = 0 and rsp_error_o = 0.
REQ-037 There is no response backpressure; the requester always accepts rsp_valid_o.
REQ-038 Request inputs are ignored outside IDLE.

Reset
REQ-039 While rst_i = 1: FSM = IDLE, captured registers = 0, req_ready_o = 1, rsp_* = 0, bank_* = 0.
REQ-040 Reset asserted mid-operation aborts the access: no response is produced and no further bank cycle occurs.

Structure
REQ-041 bank_controller_pkg holds the size enum (BYTE/HALF/WORD/ILLEGAL), the FSM state enum and BANKS_COUNT.
REQ-042 Sub-module byte_lane_router: combinational; maps offset and size to per-bank enable/row-select/write byte, and rotates plus extends read bytes.

Verification
REQ-043 Word store 0xDEADBEEF at 0x004, then load word 0x004 -> rsp_data 0xDEADBEEF at N+2; all 4 banks enabled, row 1.
REQ-044 Word store 0x11223344 at 0x007 -> bank3 row1 = 0x44, banks0/1/2 row2 = 0x33/0x22/0x11; reload returns 0x11223344.
REQ-045 Byte 0x80 at 0x002: signed load -> 0xFFFFFF80, unsigned load -> 0x00000080; only bank2 enabled.
REQ-046 Half store 0xA55A at top address 4*MEMORY_SIZE-1 -> bank3 gets the top row, bank0 gets row 0 (wrap); reload returns 0x0000A55A.
REQ-047 Size = 11 -> rsp_valid and rsp_error at N+1, bank_enable = 0 throughout; req_valid held high -> next accept one cycle after the response.
REQ-048 rst_i pulsed during ACCESS -> no rsp_valid, ready = 1 immediately, bank_* = 0.
